other_bus_arbiter: RTL and testbench
====================================

// Module: other_bus_arbiter
// PURPOSE: Round-robin arbiter sharing one "other" backend port (sel/write/addr/wdata/strb/size, ready/error/rdata) among
//   NUM_REQ requesters, e.g. the AXI slave write-data and read-data engines. Grant is locked for a whole burst and
//   released on the owner's last accepted beat. The block sits between the AXI slave interface and the backend module.
// PARAMETERS
//   NUM_REQ         2    number of requesters, 2..8; index 0 = highest priority after reset
//   ADDR_WIDTH      32   backend address width
//   DATA_WIDTH      32   backend data width; STRB_WIDTH = DATA_WIDTH>>3 (localparam)
//   TIMEOUT_CYCLES  256  stall limit, used only with OTHER_ARB_TIMEOUT_EN, 2..65535
// PORTS (flattened per-requester vectors: requester i occupies slice i)
//   axi_clk_in       in   1                  single clock, all logic rising-edge
//   axi_rst_in       in   1                  synchronous reset, active-high
//   req_sel_in       in   NUM_REQ            requester i has a beat to transfer
//   req_write_in     in   NUM_REQ            1 = write beat, 0 = read beat
//   req_last_in      in   NUM_REQ            current beat is the last of the burst
//   req_addr_in      in   NUM_REQ*ADDR_WIDTH beat address
//   req_wdata_in     in   NUM_REQ*DATA_WIDTH write data
//   req_strb_in      in   NUM_REQ*STRB_WIDTH write strobes
//   req_size_in      in   NUM_REQ*3          AXI size code of the beat
//   req_ready_out    out  NUM_REQ            beat accepted by the backend (owner only)
//   req_error_out    out  NUM_REQ            accepted beat errored or timed out (owner only)
//   req_rdata_out    out  DATA_WIDTH         backend read data, broadcast to all requesters
//   grant_valid_out  out  1                  a requester owns the backend
//   grant_idx_out    out  3                  index of the owner; valid when grant_valid_out=1
//   other_sel_out    out  1                  backend select
//   other_write_out  out  1                  backend direction
//   other_addr_out   out  ADDR_WIDTH         backend address
//   other_wdata_out  out  DATA_WIDTH         backend write data
//   other_strb_out   out  STRB_WIDTH         backend strobes
//   other_size_out   out  3                  backend size code
//   other_ready_in   in   1                  backend completes the beat this cycle
//   other_error_in   in   1                  backend error, qualified by other_ready_in
//   other_rdata_in   in   DATA_WIDTH         backend read data
// BEHAVIOUR
// - FSM IDLE/BUSY with registers grant_idx and last_idx. Reset: IDLE, grant_idx=0, last_idx=NUM_REQ-1,
//   grant_valid_out=0, timeout counter=0. Reset mid-burst drops the grant in the next cycle; no beat completes.
// - IDLE: if any req_sel_in is set, the winner is the first set bit scanning from (last_idx+1) mod NUM_REQ upward
//   with wrap. Next cycle: BUSY, grant_idx=winner, last_idx=winner. Arbitration latency is 1 cycle.
// - The backend outputs are a combinational mux of slice grant_idx while BUSY, and all 0 in IDLE.
//   other_sel_out = BUSY & req_sel_in[grant_idx]. A deasserted sel is a bubble; the grant is kept.
// - beat = other_sel_out & other_ready_in. req_ready_out[grant_idx] = beat; req_error_out[grant_idx] = beat &
//   other_error_in. Every non-owner ready/error bit is 0. req_rdata_out = other_rdata_in always.
// - BUSY -> IDLE when beat & req_last_in[grant_idx]. IDLE always lasts at least 1 cycle between bursts,
//   so there are no back-to-back grants. Requests from non-owners during BUSY wait; they are never dropped.
// - A single-beat burst (sel & last on the first beat) is legal. An error does not end the burst early.
// CONFIGURATION
// - OTHER_ARB_TIMEOUT_EN defined: a 16-bit counter clears on entry to BUSY and on every beat, and increments on every
//   other BUSY cycle. When it reaches TIMEOUT_CYCLES it pulses req_ready_out and req_error_out of the owner for 1 cycle,
//   drives other_sel_out=0 that cycle, and the FSM returns to IDLE.
// - Not defined: no counter, TIMEOUT_CYCLES is ignored, a stalled backend holds the grant until reset.
// TESTING
// - Reset with all sel=0 -> all outputs 0, grant_valid_out=0 for 5 cycles; pulse axi_rst_in mid-burst -> IDLE next cycle.
// - NUM_REQ=2, req0 and req1 sel=1 at cycle 0, single beats, ready=1 -> grant 0 at cyc1, 1 idle cycle, grant 1 at cyc3.
// - NUM_REQ=3, all requesters continuous single-beat bursts -> grant order 0,1,2,0,1,2; no requester starves.
// - req0 4-beat write burst at 0x100..0x10C with ready=1, req1 raises sel at beat 1 -> req1 granted only after beat 4 + 1 idle.
// - Read beat with other_error_in=1 and ready=1 on beat 2 -> req_error_out[owner]=1 that cycle only; burst continues.
// - OTHER_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, ready stuck 0 -> error+ready pulse 8 cycles after grant; FSM back to IDLE.

Source files
------------

// File: rtl/other_bus_arbiter.sv
// -----------------------------------------------------------------------------
// other_bus_arbiter
//   Round-robin arbiter sharing one "other" backend port among NUM_REQ
//   requesters. A grant is held for a whole burst and released on the
//   owner's last accepted beat. At least one IDLE cycle separates bursts.
//
//   Optional feature: define OTHER_ARB_TIMEOUT_EN to enable a stall
//   watchdog. When the backend stalls for TIMEOUT_CYCLES cycles, the owner
//   gets a ready+error pulse and the grant is dropped.
//
// Ports (per-requester vectors are flattened; requester i owns slice i)
//   axi_clk_in / axi_rst_in     clock, synchronous active-high reset
//   req_sel/write/last_in       per-requester beat request qualifiers
//   req_addr/wdata/strb/size_in per-requester beat payload
//   req_ready/error_out         beat completion, owner only
//   req_rdata_out               backend read data, broadcast to all requesters
//   grant_valid/idx_out         current owner
//   other_*_out / other_*_in    backend port
// -----------------------------------------------------------------------------
module other_bus_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int STRB_WIDTH    = DATA_WIDTH >> 3
) (
   input  logic                          axi_clk_in,
   input  logic                          axi_rst_in,
   input  logic [NUM_REQ-1:0]            req_sel_in,
   input  logic [NUM_REQ-1:0]            req_write_in,
   input  logic [NUM_REQ-1:0]            req_last_in,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_in,
   input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb_in,
   input  logic [NUM_REQ*3-1:0]          req_size_in,
   output logic [NUM_REQ-1:0]            req_ready_out,
   output logic [NUM_REQ-1:0]            req_error_out,
   output logic [DATA_WIDTH-1:0]         req_rdata_out,
   output logic                          grant_valid_out,
   output logic [2:0]                    grant_idx_out,
   output logic                          other_sel_out,
   output logic                          other_write_out,
   output logic [ADDR_WIDTH-1:0]         other_addr_out,
   output logic [DATA_WIDTH-1:0]         other_wdata_out,
   output logic [STRB_WIDTH-1:0]         other_strb_out,
   output logic [2:0]                    other_size_out,
   input  logic                          other_ready_in,
   input  logic                          other_error_in,
   input  logic [DATA_WIDTH-1:0]         other_rdata_in
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t                r_state, w_state_nxt;
   logic [2:0]            r_grant_idx, w_grant_nxt;
   logic [2:0]            r_last_idx, w_last_nxt;
   logic [2:0]            w_winner;
   logic                  w_busy, w_beat, w_timeout;
   logic                  w_own_sel, w_own_write, w_own_last;
   logic [ADDR_WIDTH-1:0] w_own_addr;
   logic [DATA_WIDTH-1:0] w_own_wdata;
   logic [STRB_WIDTH-1:0] w_own_strb;
   logic [2:0]            w_own_size;

   assign w_busy          = (r_state == S_BUSY);
   assign grant_valid_out = w_busy;
   assign grant_idx_out   = r_grant_idx;
   assign req_rdata_out   = other_rdata_in;

   // Round-robin pick: first requester at or after last_idx+1, with wrap.
   // The outer loop runs from the farthest offset to the nearest, so the
   // nearest requester is the last assignment and wins.
   always_comb begin
      w_winner = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ((i == (int'(r_last_idx) + k) % NUM_REQ) && req_sel_in[i])
               w_winner = 3'(i);
         end
      end
   end

   // Owner slice mux. The compare loop keeps every index a constant.
   always_comb begin
      w_own_sel   = 1'b0;
      w_own_write = 1'b0;
      w_own_last  = 1'b0;
      w_own_addr  = '0;
      w_own_wdata = '0;
      w_own_strb  = '0;
      w_own_size  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_idx == 3'(i)) begin
            w_own_sel   = req_sel_in[i];
            w_own_write = req_write_in[i];
            w_own_last  = req_last_in[i];
            w_own_addr  = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_own_wdata = req_wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
            w_own_strb  = req_strb_in[i*STRB_WIDTH +: STRB_WIDTH];
            w_own_size  = req_size_in[i*3 +: 3];
         end
      end
   end

`ifdef OTHER_ARB_TIMEOUT_EN
   logic [15:0] r_stall_cnt;

   // Holds at 0 while IDLE, so the count starts at 0 on entry to BUSY.
   always_ff @(posedge axi_clk_in) begin
      if (axi_rst_in || !w_busy || w_beat) r_stall_cnt <= '0;
      else                                 r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign w_timeout = w_busy & ~axi_rst_in & (r_stall_cnt == 16'(TIMEOUT_CYCLES));
`else
   assign w_timeout = 1'b0;
`endif

   // Reset suppresses sel, so no beat can complete in a reset cycle.
   assign other_sel_out   = w_busy & w_own_sel & ~w_timeout & ~axi_rst_in;
   assign w_beat          = other_sel_out & other_ready_in;
   assign other_write_out = w_busy & w_own_write;
   assign other_addr_out  = w_busy ? w_own_addr  : '0;
   assign other_wdata_out = w_busy ? w_own_wdata : '0;
   assign other_strb_out  = w_busy ? w_own_strb  : '0;
   assign other_size_out  = w_busy ? w_own_size  : '0;

   always_comb begin
      req_ready_out = '0;
      req_error_out = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grant_idx == 3'(i)) begin
            req_ready_out[i] = w_beat | w_timeout;
            req_error_out[i] = (w_beat & other_error_in) | w_timeout;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant_idx;
      w_last_nxt  = r_last_idx;
      case (r_state)
         S_IDLE: if (|req_sel_in) begin
            w_state_nxt = S_BUSY;
            w_grant_nxt = w_winner;
            w_last_nxt  = w_winner;
         end
         S_BUSY: if ((w_beat & w_own_last) | w_timeout) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge axi_clk_in) begin
      if (axi_rst_in) begin
         r_state     <= S_IDLE;
         r_grant_idx <= '0;
         r_last_idx  <= 3'(NUM_REQ - 1);
      end else begin
         r_state     <= w_state_nxt;
         r_grant_idx <= w_grant_nxt;
         r_last_idx  <= w_last_nxt;
      end
   end

endmodule

// File: tb/tb_other_bus_arbiter.sv
module tb_other_bus_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW >> 3;
  localparam int TO = 8;

  logic          clk, rst;
  logic [N-1:0]  sel, wr, last;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N*SW-1:0] strb;
  logic [N*3-1:0]  size;
  logic [N-1:0]  rdy, err;
  logic [DW-1:0] rdata_o, rdata_i;
  logic          gv;
  logic [2:0]    gidx;
  logic          osel, owr, ready, berr;
  logic [AW-1:0] oaddr;
  logic [DW-1:0] owdata;
  logic [SW-1:0] ostrb;
  logic [2:0]    osize;

  other_bus_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .axi_clk_in(clk), .axi_rst_in(rst),
    .req_sel_in(sel), .req_write_in(wr), .req_last_in(last),
    .req_addr_in(addr), .req_wdata_in(wdata), .req_strb_in(strb), .req_size_in(size),
    .req_ready_out(rdy), .req_error_out(err), .req_rdata_out(rdata_o),
    .grant_valid_out(gv), .grant_idx_out(gidx),
    .other_sel_out(osel), .other_write_out(owr), .other_addr_out(oaddr),
    .other_wdata_out(owdata), .other_strb_out(ostrb), .other_size_out(osize),
    .other_ready_in(ready), .other_error_in(berr), .other_rdata_in(rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  // Reference model: owner (-1 = nobody), previous winner, stall count.
  int m_owner = -1;
  int m_prev  = N - 1;
  int m_cnt   = 0;
  bit m_beat, m_to;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW]  = $urandom;
      wdata[i*DW +: DW] = $urandom;
      strb[i*SW +: SW]  = SW'($urandom);
      size[i*3 +: 3]    = 3'($urandom);
    end
    rdata_i = $urandom;
  endtask

  // Inputs are driven just after the edge; outputs are compared mid-cycle.
  task automatic settle_check();
    bit busy, esel;
    int o;
    logic [N-1:0] erdy, eerr;
    #3;
    busy = (m_owner >= 0);
    o    = busy ? m_owner : 0;
    m_to = 1'b0;
`ifdef OTHER_ARB_TIMEOUT_EN
    m_to = busy && !rst && (m_cnt == TO);
`endif
    esel   = busy && sel[o] && !rst && !m_to;
    m_beat = esel && ready;
    erdy = '0;
    eerr = '0;
    if (busy) begin
      erdy[o] = m_beat || m_to;
      eerr[o] = (m_beat && berr) || m_to;
    end
    check("grant_valid", 64'(gv), 64'(busy));
    if (busy) check("grant_idx", 64'(gidx), 64'(o));
    check("other_sel",   64'(osel),   64'(esel));
    check("other_write", 64'(owr),    busy ? 64'(wr[o]) : 64'd0);
    check("other_addr",  64'(oaddr),  busy ? 64'(addr[o*AW +: AW]) : 64'd0);
    check("other_wdata", 64'(owdata), busy ? 64'(wdata[o*DW +: DW]) : 64'd0);
    check("other_strb",  64'(ostrb),  busy ? 64'(strb[o*SW +: SW]) : 64'd0);
    check("other_size",  64'(osize),  busy ? 64'(size[o*3 +: 3]) : 64'd0);
    check("req_ready",   64'(rdy),    64'(erdy));
    check("req_error",   64'(err),    64'(eerr));
    check("req_rdata",   64'(rdata_o), 64'(rdata_i));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_prev = N - 1; m_cnt = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (sel[(m_prev + k) % N]) begin
          m_owner = (m_prev + k) % N;
          m_prev  = m_owner;
          m_cnt   = 0;
          break;
        end
      end
    end else if (m_to || (m_beat && last[m_owner])) begin
      m_owner = -1;
    end else if (m_beat) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    #1;
  endtask

  task automatic step();
    settle_check();
    tick();
  endtask

  initial begin
    rst = 1'b1; sel = '0; wr = '0; last = '0; ready = 1'b0; berr = 1'b0;
    addr = '0; wdata = '0; strb = '0; size = '0; rdata_i = '0;
    tick();

    // Reset with nothing requesting: everything stays quiet.
    for (int c = 0; c < 5; c++) begin
      settle_check();
      check("rst_gv", 64'(gv), 64'd0);
      tick();
    end
    rst = 1'b0;

    // Two single-beat requesters: grant 0, one idle cycle, grant 1.
    rand_payload();
    sel = 3'b011; last = 3'b111; ready = 1'b1;
    settle_check(); check("A_c0_gv", 64'(gv), 64'd0); tick();
    settle_check(); check("A_c1_idx", 64'(gidx), 64'd0); check("A_c1_rdy", 64'(rdy), 64'b001); tick();
    settle_check(); check("A_c2_gv", 64'(gv), 64'd0); tick();
    sel = 3'b010;
    settle_check(); check("A_c3_gv", 64'(gv), 64'd1); check("A_c3_idx", 64'(gidx), 64'd1); tick();
    sel = 3'b000;
    step();

    // req0 4-beat write burst; req1 arrives on beat 1 and must wait.
    rand_payload();
    sel = 3'b001; wr = 3'b001; last = 3'b000; ready = 1'b1;
    step();
    sel = 3'b011;
    for (int b = 0; b < 4; b++) begin
      addr[0 +: AW] = 32'h100 + 32'(4 * b);
      if (b == 3) last = 3'b001;
      settle_check();
      check("B_idx", 64'(gidx), 64'd0);
      check("B_addr", 64'(oaddr), 64'h100 + 64'(4 * b));
      check("B_rdy", 64'(rdy), 64'b001);
      tick();
    end
    sel = 3'b010; last = 3'b000; wr = 3'b000;
    settle_check(); check("B_gap_gv", 64'(gv), 64'd0); tick();

    // req1 read burst: error on beat 2 only, burst carries on.
    settle_check(); check("C_b1_idx", 64'(gidx), 64'd1); check("C_b1_err", 64'(err), 64'd0); tick();
    berr = 1'b1; rdata_i = $urandom;
    settle_check(); check("C_b2_err", 64'(err), 64'b010); check("C_b2_rdy", 64'(rdy), 64'b010); tick();
    berr = 1'b0; last = 3'b010;
    settle_check(); check("C_b3_gv", 64'(gv), 64'd1); check("C_b3_err", 64'(err), 64'd0); tick();
    sel = 3'b000; last = 3'b000;
    step();

    // Reset in the middle of a stalled burst.
    sel = 3'b100; ready = 1'b0;
    step();
    step();
    rst = 1'b1; ready = 1'b1;
    settle_check(); check("R_rdy", 64'(rdy), 64'd0); check("R_gv", 64'(gv), 64'd1); tick();
    rst = 1'b0; sel = 3'b000;
    settle_check(); check("R_next_gv", 64'(gv), 64'd0); tick();

    // All requesters continuously busy: strict 0,1,2 rotation.
    sel = 3'b111; last = 3'b111; ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle_check();
      if (c % 2 == 1) begin
        check("F_gv", 64'(gv), 64'd1);
        check("F_idx", 64'(gidx), 64'((c / 2) % 3));
      end
      tick();
    end

    // Stalled backend.
    sel = 3'b001; last = 3'b001; ready = 1'b0;
    step();
    for (int j = 0; j < 12; j++) begin
      settle_check();
`ifdef OTHER_ARB_TIMEOUT_EN
      if (j == 8) begin
        check("T_rdy", 64'(rdy), 64'b001);
        check("T_err", 64'(err), 64'b001);
        check("T_sel", 64'(osel), 64'd0);
      end
`endif
      tick();
    end
`ifndef OTHER_ARB_TIMEOUT_EN
    check("S_hold_gv", 64'(gv), 64'd1);
    check("S_hold_idx", 64'(gidx), 64'd0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(149) == 0);
      for (int i = 0; i < N; i++) begin
        sel[i]  = ($urandom_range(9) < 7);
        last[i] = ($urandom_range(9) < 3);
        wr[i]   = 1'($urandom);
      end
      rand_payload();
      ready = ($urandom_range(3) != 0);
      berr  = ($urandom_range(4) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
